infer_result_collector: RTL

//  Sits directly downstream of the inference top (class_op/done outputs).
//  - Captures each final class decision and pairs it with the image's ground-truth label.
//  - Buffers the results in a FIFO with a valid/ready stream output to the host/DMA side.
//  - Keeps running statistics: image count, correct count and a per-class prediction histogram.

---
 rtl/infer_result_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/infer_result_collector.sv
// infer_result_collector: pairs each inference decision with its ground-truth
// label, queues the result word for the host/DMA stream and keeps running
// accuracy statistics plus a per-class prediction histogram.
module infer_result_collector #(
    parameter int CLASSN = 10,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int CW    = $clog2(CLASSN),
    localparam int DW    = 2 + 2 * CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done_in,
    input  logic [CW-1:0]    class_in,
    input  logic             label_valid,
    input  logic [CW-1:0]    label_in,
    input  logic             clear_stats,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] img_count,
    output logic [CNT_W-1:0] correct_count,
    input  logic [CW-1:0]    hist_rd_addr,
    output logic [CNT_W-1:0] hist_rd_data,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] CLASSN_C = CLASSN[CW:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             done_q;
    logic             lab_pend_q;
    logic [CW-1:0]    lab_q;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [CNT_W-1:0] img_q, corr_q, rd_q;
    logic [CNT_W-1:0] hist_q [CLASSN];
    logic             ovf_q;

    logic             ev, has_label, match, empty, full, pop, push, accept;
    logic [CW-1:0]    lab_eff, lab_field;
    logic [DW-1:0]    word;
    logic [CNT_W-1:0] rd_d;

    // Rising-edge event and result word assembly; a same-cycle label wins
    always_comb begin
        ev        = done_in & ~done_q;
        has_label = lab_pend_q | label_valid;
        lab_eff   = label_valid ? label_in : lab_q;
        match     = has_label && (lab_eff == class_in);
        lab_field = has_label ? lab_eff : '0;
        word      = {has_label, match, lab_field, class_in};
    end

    // FIFO status and handshake; full FIFO still accepts when a pop frees a slot
    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop    = !empty && m_ready;
        push   = ev && (!full || pop);
        accept = push && !clear_stats;
    end

    assign m_valid       = !empty;
    assign m_data        = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign img_count     = img_q;
    assign correct_count = corr_q;
    assign hist_rd_data  = rd_q;
    assign overflow      = ovf_q;

    // Edge detector and label latch; an event always consumes the pending label
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q     <= 1'b0;
            lab_pend_q <= 1'b0;
            lab_q      <= '0;
        end else begin
            done_q <= done_in;
            if (ev) begin
                lab_pend_q <= 1'b0;
            end else if (label_valid) begin
                lab_pend_q <= 1'b1;
                lab_q      <= label_in;
            end
        end
    end

    // FIFO pointers; storage has no reset since m_data is masked while empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= word;
    end

    // Saturating counters and sticky overflow; clear beats a same-cycle event
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            img_q  <= '0;
            corr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept && img_q != CNT_MAX)          img_q  <= img_q + 1'b1;
            if (accept && match && corr_q != CNT_MAX) corr_q <= corr_q + 1'b1;
            if (ev && !push)                          ovf_q  <= 1'b1;
        end
    end

    // Histogram bins, one saturating counter per class
    for (genvar i = 0; i < CLASSN; i++) begin : g_bin
        // Bin i counts accepted results whose class equals i
        always_ff @(posedge clk) begin
            if (reset || clear_stats) begin
                hist_q[i] <= '0;
            end else if (accept && class_in == CW'(i) && hist_q[i] != CNT_MAX) begin
                hist_q[i] <= hist_q[i] + 1'b1;
            end
        end
    end

    // Histogram read mux; out-of-range addresses read as zero
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < CLASSN; i++) begin
            if ({1'b0, hist_rd_addr} < CLASSN_C && hist_rd_addr == CW'(i)) rd_d = hist_q[i];
        end
    end

    // Registered read port; sees pre-increment bin values
    always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end
endmodule
